// File: rtl/sgf_seq_divider_pkg.sv
// Shared definitions for the sequential significand divider: FSM state
// encoding and the iteration-counter width helper.
package sgf_seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must hold SW+2 iterations.
    function automatic int cnt_width(input int sw);
        return $clog2(sw + 3);
    endfunction

endpackage

// File: rtl/sgf_seq_divider_if.sv
// Start/done handshake and operand/result bundle between the unpacker,
// the significand divider and the rounder.
interface sgf_seq_divider_if #(
    parameter int SW = 54
);
    logic          start_i;
    logic [SW-1:0] Data_A_i;
    logic [SW-1:0] Data_B_i;
    logic          ready_o;
    logic          done_o;
    logic [SW+1:0] quotient_o;
    logic          sticky_o;
    logic          div_zero_o;

    modport master (
        output start_i, Data_A_i, Data_B_i,
        input  ready_o, done_o, quotient_o, sticky_o, div_zero_o
    );

    modport slave (
        input  start_i, Data_A_i, Data_B_i,
        output ready_o, done_o, quotient_o, sticky_o, div_zero_o
    );
endinterface

// File: rtl/sgf_seq_divider_substractor.sv
// Plain W-bit subtractor; the divider uses the MSB of the difference as the
// sign of the trial remainder.
module substractor #(
    parameter int W = 56
) (
    input  logic [W-1:0] Data_A_i,
    input  logic [W-1:0] Data_B_i,
    output logic [W-1:0] Data_S_o
);
    assign Data_S_o = Data_A_i - Data_B_i;
endmodule

// File: rtl/sgf_seq_divider.sv
// Radix-2 restoring significand divider: one quotient bit per cycle, SW+2
// quotient bits (two guard positions) plus a sticky bit from the remainder.
module sgf_seq_divider
    import sgf_seq_divider_pkg::*;
#(
    parameter int SW = 54
) (
    input  logic               clk,
    input  logic               rst,
    sgf_seq_divider_if.slave   bus
);
    localparam int CW = cnt_width(SW);

    div_state_t    state_q, state_d;
    logic [SW:0]   rem_q, rem_d;
    logic [SW-1:0] div_q, div_d;
    logic [SW+1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW+1:0] quotient_q, quotient_d;
    logic          sticky_q, sticky_d;
    logic          dz_q, dz_d;

    logic [SW+1:0] trial;
    logic          q_bit;
    logic [SW:0]   rem_fit;

    substractor #(.W(SW + 2)) u_sub (
        .Data_A_i ({1'b0, rem_q}),
        .Data_B_i ({2'b00, div_q}),
        .Data_S_o (trial)
    );

    // Non-negative trial keeps the difference; R < 2D guarantees it fits SW+1 bits.
    assign q_bit   = ~trial[SW+1];
    assign rem_fit = q_bit ? trial[SW:0] : rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            quotient_q <= '0;
            sticky_q   <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
            sticky_q   <= sticky_d;
            dz_q       <= dz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        sticky_d   = sticky_q;
        dz_d       = dz_q;

        case (state_q)
            CALC: begin
                rem_d = {rem_fit[SW-1:0], 1'b0};
                quo_d = {quo_q[SW:0], q_bit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = DONE;
                    quotient_d = {quo_q[SW:0], q_bit};
                    sticky_d   = |rem_fit;
                    dz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // IDLE and DONE both accept, which gives back-to-back operation.
        if (state_q != CALC && bus.start_i) begin
            if (bus.Data_B_i == '0) begin
                state_d    = DONE;
                quotient_d = '1;
                sticky_d   = 1'b1;
                dz_d       = 1'b1;
            end else begin
                state_d = CALC;
                rem_d   = {1'b0, bus.Data_A_i};
                div_d   = bus.Data_B_i;
                quo_d   = '0;
                cnt_d   = CW'(SW + 2);
            end
        end
    end

    assign bus.ready_o    = (state_q != CALC);
    assign bus.done_o     = (state_q == DONE);
    assign bus.quotient_o = quotient_q;
    assign bus.sticky_o   = sticky_q;
    assign bus.div_zero_o = dz_q;

endmodule
